// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode/funct encodings, fetch FSM states and
// small helpers used by the fetch stage.
package mips_pkg;

    typedef enum logic [5:0] {
        FUNCT_OP = 6'h00,
        J_OP     = 6'h02,
        BEQ_OP   = 6'h04,
        BNE_OP   = 6'h05,
        LUI_OP   = 6'h0F,
        LW_OP    = 6'h23,
        SW_OP    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        NOP   = 6'h00,
        BREAK = 6'h0D,
        ADD   = 6'h20,
        SUB   = 6'h22,
        AND   = 6'h24,
        XOR   = 6'h26
    } funct_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic pc_aligned(input logic [31:0] pc_in);
        return (pc_in[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_ir.sv
// Instruction register: 32-bit IR with synchronous clear/load and the
// fixed MIPS field slicing used by the control FSM.
module instr_register (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [31:0] i_data,
    output logic [5:0]  o_op,
    output logic [5:0]  o_funct,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_shamt,
    output logic [15:0] o_imm16,
    output logic [25:0] o_jaddr
);

    logic [31:0] r_ir;

    // IR storage; clear wins over load so an aborted or misaligned fetch reads as NOP
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_ir <= 32'h0000_0000;
        end else if (i_clr) begin
            r_ir <= 32'h0000_0000;
        end else if (i_load) begin
            r_ir <= i_data;
        end else begin
            r_ir <= r_ir;
        end
    end

    assign o_op    = r_ir[31:26];
    assign o_rs    = r_ir[25:21];
    assign o_rt    = r_ir[20:16];
    assign o_rd    = r_ir[15:11];
    assign o_shamt = r_ir[10:6];
    assign o_funct = r_ir[5:0];
    assign o_imm16 = r_ir[15:0];
    assign o_jaddr = r_ir[25:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle MIPS core: owns PC, times instruction memory
// reads and hands a decoded IR to the control FSM via instr_valid.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int          MEM_LATENCY = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        fetch_req,
    input  logic        ir_clr,
    input  logic        pc_write,
    input  logic [31:0] pc_next,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] pc,
    output logic        busy,
    output logic        instr_valid,
    output logic        addr_err,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [4:0]  Shamt,
    output logic [15:0] Imm16,
    output logic [25:0] JAddr
);

    localparam int             CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_auto;
    logic [31:0]      w_pc_nxt;
    logic             r_addr_err;
    logic             w_addr_err_nxt;
    logic             w_ir_load;
    logic             w_ir_clr;
    logic             w_aligned;

    assign w_aligned = pc_aligned(r_pc);

    // Next-state, counter, PC-increment and IR control decode
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_addr_err_nxt = r_addr_err;
        w_pc_auto      = r_pc;
        w_ir_load      = 1'b0;
        w_ir_clr       = 1'b0;
        if (ir_clr) begin
            w_state_nxt    = ST_IDLE;
            w_cnt_nxt      = CNT_ZERO;
            w_addr_err_nxt = 1'b0;
            w_ir_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_VALID: begin
                    if (fetch_req && w_aligned) begin
                        w_state_nxt    = ST_READ;
                        w_cnt_nxt      = CNT_LOAD;
                        w_addr_err_nxt = 1'b0;
                    end else if (fetch_req) begin
                        // misaligned PC: skip memory, present a NOP flagged by addr_err
                        w_state_nxt    = ST_VALID;
                        w_addr_err_nxt = 1'b1;
                        w_ir_clr       = 1'b1;
                    end else begin
                        w_state_nxt    = r_state;
                    end
                end
                ST_READ: begin
                    if (r_cnt != CNT_ZERO) begin
                        w_cnt_nxt   = r_cnt - CNT_ONE;
                    end else begin
                        w_ir_load   = 1'b1;
                        w_pc_auto   = r_pc + PC_STEP;
                        w_state_nxt = ST_VALID;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // A datapath PC load overrides the sequential increment on the same edge
    assign w_pc_nxt = pc_write ? pc_next : w_pc_auto;

    // State, latency counter, PC and alignment flag registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= CNT_ZERO;
            r_pc       <= RESET_PC;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pc       <= w_pc_nxt;
            r_addr_err <= w_addr_err_nxt;
        end
    end

    instr_register u_ir (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_clr   (w_ir_clr),
        .i_load  (w_ir_load),
        .i_data  (mem_rdata),
        .o_op    (Op),
        .o_funct (Funct),
        .o_rs    (Rs),
        .o_rt    (Rt),
        .o_rd    (Rd),
        .o_shamt (Shamt),
        .o_imm16 (Imm16),
        .o_jaddr (JAddr)
    );

    assign mem_addr    = r_pc;
    assign pc          = r_pc;
    assign mem_rd      = (r_state == ST_READ);
    assign busy        = (r_state == ST_READ);
    assign instr_valid = (r_state == ST_VALID);
    assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle-level behavioural model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_instr_fetch_unit;

    localparam int LAT = 2;

    logic        Clk;
    logic        Reset;
    logic        fetch_req;
    logic        ir_clr;
    logic        pc_write;
    logic [31:0] pc_next;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] pc;
    logic        busy;
    logic        instr_valid;
    logic        addr_err;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [4:0]  Shamt;
    logic [15:0] Imm16;
    logic [25:0] JAddr;

    logic [31:0] mem [0:63];
    int          total;
    int          bad;
    int          prot_viol;

    instr_fetch_unit #(.MEM_LATENCY(LAT), .RESET_PC(32'h0000_0000)) dut (
        .Clk(Clk), .Reset(Reset), .fetch_req(fetch_req), .ir_clr(ir_clr),
        .pc_write(pc_write), .pc_next(pc_next), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .pc(pc), .busy(busy),
        .instr_valid(instr_valid), .addr_err(addr_err), .Op(Op), .Funct(Funct),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Imm16(Imm16), .JAddr(JAddr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    // Model: reads_left counts remaining memory-read cycles (0 = not reading)
    typedef struct {
        int unsigned reads_left;
        bit          valid;
        bit          err;
        logic [31:0] pc;
        logic [31:0] ir;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_reset();
        mstate_t n;
        n.reads_left = 0;
        n.valid      = 1'b0;
        n.err        = 1'b0;
        n.pc         = 32'h0000_0000;
        n.ir         = 32'h0000_0000;
        return n;
    endfunction

    function automatic mstate_t model_step(mstate_t s, logic fr, logic clr, logic pw, logic [31:0] pn);
        mstate_t     n;
        logic [31:0] pc_after;
        n        = s;
        pc_after = s.pc;
        if (clr) begin
            n.ir = 32'h0; n.reads_left = 0; n.valid = 1'b0; n.err = 1'b0;
        end else if (s.reads_left > 0) begin
            if (s.reads_left == 1) begin
                n.ir = mem[s.pc[7:2]]; pc_after = s.pc + 32'd4;
                n.valid = 1'b1; n.reads_left = 0;
            end else begin
                n.reads_left = s.reads_left - 1;
            end
        end else if (fr) begin
            if (s.pc[1:0] != 2'b00) begin
                n.ir = 32'h0; n.err = 1'b1; n.valid = 1'b1;
            end else begin
                n.reads_left = LAT; n.valid = 1'b0; n.err = 1'b0;
            end
        end
        n.pc = pw ? pn : pc_after;
        return n;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) m <= model_reset();
        else        m <= model_step(m, fetch_req, ir_clr, pc_write, pc_next);
    end

    // Moving PC while an address is being presented (other than the capture edge)
    always @(posedge Clk) begin
        if (Reset && pc_write && m.reads_left > 1) prot_viol <= prot_viol + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("pc",       pc, m.pc);
        check("mem_addr", mem_addr, m.pc);
        check("mem_rd",   32'(mem_rd), 32'(m.reads_left != 0));
        check("busy",     32'(busy), 32'(m.reads_left != 0));
        check("valid",    32'(instr_valid), 32'(m.valid));
        check("addr_err", 32'(addr_err), 32'(m.err));
        check("fields",   {Op, Rs, Rt, Rd, Shamt, Funct}, m.ir);
        check("imm16",    {16'h0, Imm16}, {16'h0, m.ir[15:0]});
        check("jaddr",    {6'h0, JAddr}, {6'h0, m.ir[25:0]});
    endtask

    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
        compare_all();
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!instr_valid && n < budget) begin
            cyc();
            n++;
        end
        check("valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    initial begin
        total = 0; bad = 0; prot_viol = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h8C22_0004;
        mem[1]  = 32'h0043_0820;
        mem[2]  = 32'h0800_0010;
        mem[16] = 32'h3C01_ABCD;
        mem[63] = 32'h1000_FFFF;
        Reset = 1'b0; fetch_req = 1'b0; ir_clr = 1'b0; pc_write = 1'b0; pc_next = 32'h0;
        m = model_reset();
        cyc(); cyc();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        Reset = 1'b1;
        cyc();

        // plain LW fetch from PC 0
        fetch_req = 1'b1; cyc(); fetch_req = 1'b0;
        check("t2_rd_k1", 32'(mem_rd), 32'd1);
        cyc();
        check("t2_rd_k2", 32'(mem_rd), 32'd1);
        check("t2_nv_k2", 32'(instr_valid), 32'd0);
        cyc();
        check("t2_valid", 32'(instr_valid), 32'd1);
        check("t2_rd_off", 32'(mem_rd), 32'd0);
        check("t2_op", 32'(Op), 32'h23);
        check("t2_rs", 32'(Rs), 32'd1);
        check("t2_rt", 32'(Rt), 32'd2);
        check("t2_imm", 32'(Imm16), 32'h4);
        check("t2_pc", pc, 32'h4);

        // back-to-back fetch, request held through READ
        fetch_req = 1'b1; cyc();
        check("t3_drop", 32'(instr_valid), 32'd0);
        cyc();
        check("t3_pc_hold", pc, 32'h4);
        cyc(); fetch_req = 1'b0;
        check("t3_valid", 32'(instr_valid), 32'd1);
        check("t3_pc", pc, 32'h8);
        check("t3_funct", 32'(Funct), 32'h20);
        check("t3_rd", 32'(Rd), 32'd1);
        check("t3_rs", 32'(Rs), 32'd2);

        // pc_write on the capture edge
        fetch_req = 1'b1; cyc(); fetch_req = 1'b0;
        cyc(); pc_write = 1'b1; pc_next = 32'h40;
        cyc(); pc_write = 1'b0;
        check("t4_pc", pc, 32'h40);
        check("t4_op", 32'(Op), 32'h02);
        check("t4_jaddr", 32'(JAddr), 32'h10);

        // misaligned fetch from IDLE
        ir_clr = 1'b1; pc_write = 1'b1; pc_next = 32'h6; cyc();
        ir_clr = 1'b0; pc_write = 1'b0;
        check("t5_idle", 32'(instr_valid), 32'd0);
        fetch_req = 1'b1; cyc(); fetch_req = 1'b0;
        check("t5_nord", 32'(mem_rd), 32'd0);
        check("t5_err", 32'(addr_err), 32'd1);
        check("t5_valid", 32'(instr_valid), 32'd1);
        check("t5_op", 32'(Op), 32'h0);
        check("t5_pc", pc, 32'h6);

        // abort mid-read, then wrap fetch at top of address space
        ir_clr = 1'b1; pc_write = 1'b1; pc_next = 32'h40; cyc();
        ir_clr = 1'b0; pc_write = 1'b0;
        check("t6_err_clr", 32'(addr_err), 32'd0);
        fetch_req = 1'b1; cyc(); fetch_req = 1'b0; ir_clr = 1'b1;
        cyc(); ir_clr = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_nv", 32'(instr_valid), 32'd0);
        cyc();
        check("t6_op", 32'(Op), 32'h0);
        check("t6_pc", pc, 32'h40);
        pc_write = 1'b1; pc_next = 32'hFFFF_FFFC; cyc(); pc_write = 1'b0;
        fetch_req = 1'b1; cyc(); fetch_req = 1'b0;
        wait_valid(10);
        check("t6_wrap", pc, 32'h0);
        check("t6_op2", 32'(Op), 32'h04);
        check("t6_imm", 32'(Imm16), 32'hFFFF);

        // asynchronous reset in the middle of a read
        pc_write = 1'b1; pc_next = 32'h8; cyc(); pc_write = 1'b0;
        fetch_req = 1'b1; cyc(); fetch_req = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        Reset = 1'b0;
        cyc();
        check("t1_pc", pc, 32'h0);
        check("t1_rd", 32'(mem_rd), 32'd0);
        check("t1_nv", 32'(instr_valid), 32'd0);
        check("t1_op", 32'(Op), 32'h0);
        Reset = 1'b1;
        cyc(); cyc();

        check("protocol", prot_viol, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
